// File: rtl/shift_sequencer_pkg.sv
// Shared encodings and widths for the shift sequencer.
package shift_sequencer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DATA_W  = 16;
    localparam int SHAMT_W = 4;

endpackage

// File: rtl/shift_sequencer_tick_gen.sv
// Step prescaler: counts 0..TICK_DIV-1 while enabled, tick on the last count.
module tick_gen #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic tick
);
    localparam int CNT_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_cnt <= '0;
        else if (!en || r_cnt == LAST)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CNT_W'(1);
    end

    assign tick = en && (r_cnt == LAST);

endmodule

// File: rtl/shift_sequencer.sv
// Sweeps a downstream barrel shifter through shift amounts 0..15, capturing
// its result once per prescaler tick.
module shift_sequencer
    import shift_sequencer_pkg::*;
#(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               continuous,
    input  logic [DATA_W-1:0]  load_val,
    input  logic               mode_dir,
    input  logic               mode_rot,
    input  logic [DATA_W-1:0]  shifter_dout,
    output logic [DATA_W-1:0]  din_o,
    output logic [SHAMT_W-1:0] shamt_o,
    output logic               dir_o,
    output logic               rot_o,
    output logic [DATA_W-1:0]  result,
    output logic               step_strobe,
    output logic               busy,
    output logic               done
);
    localparam logic [SHAMT_W-1:0] SHAMT_MAX = '1;

    state_t r_state, w_next;
    logic [DATA_W-1:0]  r_din, r_result;
    logic [SHAMT_W-1:0] r_shamt;
    logic r_dir, r_rot;
    logic w_en, w_tick, w_cap, w_launch;

    assign w_en     = (r_state == RUN);
    assign w_launch = (r_state == IDLE) && start && !abort;
    // Abort wins over a coincident tick: no capture, no strobe, shamt frozen.
    assign w_cap    = w_tick && !abort;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   (w_en),
        .tick (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: if (w_launch) w_next = RUN;
            RUN: begin
                if (abort)
                    w_next = IDLE;
                else if (w_tick && r_shamt == SHAMT_MAX && !continuous)
                    w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_din    <= '0;
            r_shamt  <= '0;
            r_dir    <= 1'b0;
            r_rot    <= 1'b0;
            r_result <= '0;
        end else if (w_launch) begin
            r_din   <= load_val;
            r_dir   <= mode_dir;
            r_rot   <= mode_rot;
            r_shamt <= '0;
        end else if (w_cap) begin
            r_result <= shifter_dout;
            if (r_shamt != SHAMT_MAX)
                r_shamt <= r_shamt + SHAMT_W'(1);
            else if (continuous)
                r_shamt <= '0;
        end
    end

    assign din_o       = r_din;
    assign shamt_o     = r_shamt;
    assign dir_o       = r_dir;
    assign rot_o       = r_rot;
    assign result      = r_result;
    assign step_strobe = w_cap;
    assign busy        = (r_state == RUN);
    assign done        = (r_state == DONE);

endmodule

// File: tb/tb_shift_sequencer.sv
// Directed bench for shift_sequencer with TICK_DIV=4 and a behavioural
// barrel shifter (dir=0 shifts left, dir=1 shifts right).
module tb_shift_sequencer;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, abort = 1'b0, continuous = 1'b0;
    logic [15:0] load_val = '0;
    logic        mode_dir = 1'b0, mode_rot = 1'b0;
    logic [15:0] shifter_dout;
    logic [15:0] din_o, result;
    logic [3:0]  shamt_o;
    logic        dir_o, rot_o, step_strobe, busy, done;

    int n_chk = 0, n_pass = 0, cyc = 0;
    logic [15:0] res_log [16];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] shf(input logic [15:0] x, input logic [3:0] s,
                                        input logic d, input logic r);
        logic [31:0] w;
        if (!d) begin
            w = {x, x} << s;
            return r ? w[31:16] : (x << s);
        end else begin
            w = {x, x} >> s;
            return r ? w[15:0] : (x >> s);
        end
    endfunction

    assign shifter_dout = shf(din_o, shamt_o, dir_o, rot_o);

    shift_sequencer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .continuous(continuous),
        .load_val(load_val), .mode_dir(mode_dir), .mode_rot(mode_rot),
        .shifter_dout(shifter_dout), .din_o(din_o), .shamt_o(shamt_o),
        .dir_o(dir_o), .rot_o(rot_o), .result(result), .step_strobe(step_strobe),
        .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic kick(input logic [15:0] v, input logic d, input logic r,
                        input logic c, output int t0);
        @(posedge clk); #1;
        load_val = v; mode_dir = d; mode_rot = r; continuous = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        t0 = cyc;
        chk("busy_after_start", busy, 1);
    endtask

    // Follows a sweep, checking every strobe and the captured result after it.
    task automatic watch(input logic [15:0] v, input logic d, input logic r,
                         input int want, input int t0, output int n, output int done_at);
        int  k;
        logic pend;
        pend = 1'b0; n = 0; done_at = -1; k = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (pend) begin
                res_log[k] = result;
                chk($sformatf("result_s%0d", k), result, shf(v, k[3:0], d, r));
                pend = 1'b0;
                if (n == want) break;
            end
            if (done) begin
                chk("strobe_done_excl", step_strobe, 0);
                done_at = cyc - t0;
                break;
            end
            if (step_strobe) begin
                chk($sformatf("strobe_shamt%0d", n), shamt_o, n);
                if (n == 0) chk("first_strobe_lat", cyc - t0, 3);
                k = n; pend = 1'b1; n++;
            end
        end
    endtask

    initial begin
        int t0, n, done_at;

        #2;
        chk("rst_din", din_o, 0);
        chk("rst_flags", {busy, step_strobe, done, dir_o, rot_o}, 0);
        chk("rst_shamt_result", {shamt_o, result}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // Logical left sweep.
        kick(16'hA738, 1'b0, 1'b0, 1'b0, t0);
        watch(16'hA738, 1'b0, 1'b0, 99, t0, n, done_at);
        chk("sweep1_strobes", n, 16);
        chk("sweep1_done_lat", done_at, 64);
        chk("sweep1_shamt_end", shamt_o, 15);
        chk("sweep1_res0", res_log[0], 16'hA738);
        chk("sweep1_res1", res_log[1], 16'h4E70);
        @(negedge clk);
        chk("sweep1_idle", {busy, done}, 0);

        // Rotate-right sweep; mode inputs flip after start and must not matter.
        kick(16'hA738, 1'b1, 1'b1, 1'b0, t0);
        mode_dir = 1'b0; mode_rot = 1'b0;
        watch(16'hA738, 1'b1, 1'b1, 99, t0, n, done_at);
        chk("sweep2_strobes", n, 16);
        chk("sweep2_done_lat", done_at, 64);
        chk("sweep2_rot0", res_log[0], 16'hA738);
        chk("sweep2_rot4", res_log[4], 16'h8A73);

        // Continuous rotate-left: wraps, no done, then abort.
        kick(16'hA738, 1'b0, 1'b1, 1'b1, t0);
        watch(16'hA738, 1'b0, 1'b1, 16, t0, n, done_at);
        chk("cont_strobes", n, 16);
        chk("cont_no_done", done_at, 32'hFFFF_FFFF);
        chk("cont_shamt_wrap", shamt_o, 0);
        chk("cont_busy", busy, 1);
        #1 abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0; continuous = 1'b0;
        @(negedge clk);
        chk("cont_abort_idle", {busy, done}, 0);

        // Abort on the second tick cycle.
        kick(16'h1234, 1'b0, 1'b0, 1'b0, t0);
        while (cyc < t0 + 6) @(negedge clk);
        @(posedge clk); #1 abort = 1'b1;
        @(negedge clk);
        chk("abort_tick_strobe", step_strobe, 0);
        chk("abort_tick_result", result, 16'h1234);
        @(posedge clk); #1 abort = 1'b0;
        @(negedge clk);
        chk("abort_tick_idle", {busy, done}, 0);
        chk("abort_tick_shamt", shamt_o, 1);
        chk("abort_tick_result2", result, 16'h1234);

        // Start during RUN ignored, then reset at shamt 7.
        kick(16'hBEEF, 1'b1, 1'b0, 1'b0, t0);
        @(posedge clk); #1 load_val = 16'h0F0F; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("run_start_ignored", din_o, 16'hBEEF);
        chk("run_still_busy", busy, 1);
        for (int c = 0; c < 64; c++) begin
            if (shamt_o == 4'd7) break;
            @(negedge clk);
        end
        chk("reach_shamt7", shamt_o, 7);
        #2 rst = 1'b1;
        #1;
        chk("midrst_din", din_o, 0);
        chk("midrst_flags", {busy, step_strobe, done, dir_o, rot_o}, 0);
        chk("midrst_shamt_result", {shamt_o, result}, 0);
        @(posedge clk); @(posedge clk); #1 rst = 1'b0;
        repeat (6) @(negedge clk);
        chk("post_rst_idle", {busy, done, step_strobe}, 0);

        // start+abort together in IDLE.
        @(posedge clk); #1 load_val = 16'h5555; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", busy, 0);
        chk("start_abort_din", din_o, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
